// File: rtl/majority_persistence_detector.sv
// majority_persistence_detector
//   Each valid cycle the NBITS-wide sample is popcounted and compared with
//   THRESH, either "at least" (mode=0) or "exactly" (mode=1). The result is
//   registered one cycle. A saturating run counter asserts det only after
//   HOLD consecutive valid matches. det_pulse strobes on the rising edge of
//   det, and events counts detections modulo 2^EW.
//
// Ports
//   clk       : clock, all state on the rising edge
//   rst_n     : asynchronous active-low reset
//   clear     : synchronous clear of run/detect/event state; drops the sample
//   in_val    : sample valid
//   in        : sample bits [NBITS-1:0]
//   mode      : 0 = popcount >= THRESH, 1 = popcount == THRESH
//   out_val   : registered stage holds a sample
//   count     : registered popcount of the staged sample [CW-1:0]
//   match     : registered match of the staged sample
//   det       : HOLD consecutive valid matches seen
//   det_pulse : one-cycle strobe on det rising
//   events    : detection count, wraps [EW-1:0]
module majority_persistence_detector #(
  parameter  int NBITS  = 3,
  parameter  int THRESH = 2,
  parameter  int HOLD   = 4,
  parameter  int EW     = 8,
  localparam int CW     = $clog2(NBITS + 1),
  localparam int RW     = $clog2(HOLD + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_val,
  input  logic [NBITS-1:0] in,
  input  logic             mode,
  output logic             out_val,
  output logic [CW-1:0]    count,
  output logic             match,
  output logic             det,
  output logic             det_pulse,
  output logic [EW-1:0]    events
);

  localparam logic [CW-1:0] THRESH_C = CW'(THRESH);
  localparam logic [RW-1:0] HOLD_C   = RW'(HOLD);
  localparam logic [RW-1:0] PRE_C    = RW'(HOLD - 1);

  function automatic logic [CW-1:0] popcount(input logic [NBITS-1:0] v);
    logic [CW-1:0] c;
    c = {CW{1'b0}};
    for (int i = 0; i < NBITS; i++) begin
      if (v[i]) begin
        c = c + CW'(1);
      end else begin
        c = c;
      end
    end
    return c;
  endfunction

  logic [CW-1:0] pc_s;
  logic          m_s;
  logic          take_s;

  logic          out_val_q, out_val_d;
  logic [CW-1:0] count_q,   count_d;
  logic          match_q,   match_d;
  logic [RW-1:0] run_q,     run_d;
  logic          det_q,     det_d;
  logic          pulse_q,   pulse_d;
  logic [EW-1:0] events_q,  events_d;

  // Popcount/match of the incoming sample and next-state for all registers.
  always_comb begin
    pc_s   = popcount(in);
    m_s    = mode ? (pc_s == THRESH_C) : (pc_s >= THRESH_C);
    // clear wins over a simultaneous sample, so the sample is simply dropped
    take_s = in_val & ~clear;

    out_val_d = take_s;
    count_d   = take_s ? pc_s : count_q;
    match_d   = take_s ? m_s  : match_q;

    if (clear) begin
      run_d = {RW{1'b0}};
    end else if (in_val) begin
      if (m_s) begin
        run_d = (run_q == HOLD_C) ? HOLD_C : run_q + RW'(1);
      end else begin
        run_d = {RW{1'b0}};
      end
    end else begin
      run_d = run_q;  // bubbles neither break nor extend a run
    end

    // Pulse only on the HOLD-1 -> HOLD transition; a saturated run stays quiet
    pulse_d  = take_s & m_s & (run_q == PRE_C);
    det_d    = (run_d == HOLD_C);
    events_d = clear ? {EW{1'b0}} : (pulse_d ? events_q + EW'(1) : events_q);
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_val_q <= 1'b0;
      count_q   <= {CW{1'b0}};
      match_q   <= 1'b0;
      run_q     <= {RW{1'b0}};
      det_q     <= 1'b0;
      pulse_q   <= 1'b0;
      events_q  <= {EW{1'b0}};
    end else begin
      out_val_q <= out_val_d;
      count_q   <= count_d;
      match_q   <= match_d;
      run_q     <= run_d;
      det_q     <= det_d;
      pulse_q   <= pulse_d;
      events_q  <= events_d;
    end
  end

  assign out_val   = out_val_q;
  assign count     = count_q;
  assign match     = match_q;
  assign det       = det_q;
  assign det_pulse = pulse_q;
  assign events    = events_q;

endmodule

// File: tb/tb_majority_persistence_detector.sv
// Directed testbench for majority_persistence_detector: a default instance
// (NBITS=3, THRESH=2, HOLD=4, EW=8) and a HOLD=1, EW=2 instance for wrap.
module tb_majority_persistence_detector;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       in_val = 1'b0;
  logic [2:0] in = 3'b000;
  logic       mode = 1'b0;

  logic       out_val, match, det, det_pulse;
  logic [1:0] count;
  logic [7:0] events;

  logic       out_val2, match2, det2, det_pulse2;
  logic [1:0] count2;
  logic [1:0] events2;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  majority_persistence_detector dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_val(in_val), .in(in),
    .mode(mode), .out_val(out_val), .count(count), .match(match),
    .det(det), .det_pulse(det_pulse), .events(events)
  );

  majority_persistence_detector #(.NBITS(3), .THRESH(2), .HOLD(1), .EW(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_val(in_val), .in(in),
    .mode(mode), .out_val(out_val2), .count(count2), .match(match2),
    .det(det2), .det_pulse(det_pulse2), .events(events2)
  );

  // advance past one rising edge and settle
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_val = 1'b0; clear = 1'b0; mode = 1'b0; in = 3'b000;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    in_val = 1'b1; in = 3'b111;
    for (int i = 1; i <= 5; i++) begin
      step();
      checks++;
      if (det !== (i >= 4)) begin
        fails++; $display("FAIL pre_reset_det cycle %0d: got %b exp %b", i, det, (i >= 4));
      end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_val, count, match, det, det_pulse, events} !== 14'd0) begin
      fails++; $display("FAIL reset_immediate: got %b exp 0", {out_val, count, match, det, det_pulse, events});
    end
    step();
    checks++;
    if ({out_val, count, match, det, det_pulse, events} !== 14'd0) begin
      fails++; $display("FAIL reset_held: got %b exp 0", {out_val, count, match, det, det_pulse, events});
    end
    #2 rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++;
      if ({det, det_pulse} !== ((i == 4) ? 2'b11 : 2'b00)) begin
        fails++; $display("FAIL post_reset_det cycle %0d: got %b", i, {det, det_pulse});
      end
    end
    checks++;
    if (events !== 8'd1) begin
      fails++; $display("FAIL post_reset_events: got %0d exp 1", events);
    end
  endtask

  task automatic test_truth_table();
    logic [1:0] exp_c [8];
    logic       exp_m [8];
    exp_c = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
    exp_m = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    in_val = 1'b1; mode = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in = 3'(i);
      step();
      checks++;
      if ({out_val, count, match} !== {1'b1, exp_c[i], exp_m[i]}) begin
        fails++; $display("FAIL truth_table in=%0d: got v=%b c=%0d m=%b exp v=1 c=%0d m=%b",
                          i, out_val, count, match, exp_c[i], exp_m[i]);
      end
    end
    in_val = 1'b0;
  endtask

  task automatic test_exact_mode();
    logic [2:0] vec [3];
    logic       exp [3];
    vec = '{3'b111, 3'b101, 3'b001};
    exp = '{1'b0, 1'b1, 1'b0};
    do_reset();
    in_val = 1'b1; mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in = vec[i];
      step();
      checks++;
      if (match !== exp[i]) begin
        fails++; $display("FAIL exact_mode in=%b: got %b exp %b", vec[i], match, exp[i]);
      end
    end
    in_val = 1'b0; mode = 1'b0;
  endtask

  task automatic test_persistence_bubbles();
    logic [2:0] vec [7];
    logic       vld [7];
    vec = '{3'b110, 3'b000, 3'b011, 3'b000, 3'b000, 3'b101, 3'b111};
    vld = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      in_val = vld[i]; in = vec[i];
      step();
      checks++;
      if ({out_val, det, det_pulse} !== {vld[i], (i == 6), (i == 6)}) begin
        fails++; $display("FAIL bubbles step %0d: got v/det/pulse=%b", i, {out_val, det, det_pulse});
      end
    end
    checks++;
    if (events !== 8'd1) begin
      fails++; $display("FAIL bubbles_events: got %0d exp 1", events);
    end
    in_val = 1'b1; in = 3'b111;
    step();
    checks++;
    if ({det, det_pulse, events} !== {1'b1, 1'b0, 8'd1}) begin
      fails++; $display("FAIL saturated: got det=%b pulse=%b ev=%0d exp 1 0 1", det, det_pulse, events);
    end
    in = 3'b100;
    step();
    checks++;
    if ({det, det_pulse, match} !== 3'b000) begin
      fails++; $display("FAIL drop_after_nonmatch: got det=%b pulse=%b match=%b exp 0 0 0", det, det_pulse, match);
    end
    in_val = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    in_val = 1'b1;
    for (int r = 0; r < 3; r++) begin
      in = 3'b011;
      for (int i = 1; i <= ((r == 0) ? 3 : 4); i++) begin
        step();
        checks++;
        if ({det, det_pulse} !== (((r > 0) && (i == 4)) ? 2'b11 : 2'b00)) begin
          fails++; $display("FAIL broken_run r=%0d i=%0d: got det/pulse=%b", r, i, {det, det_pulse});
        end
      end
      checks++;
      if (events !== 8'(r)) begin
        fails++; $display("FAIL broken_run_events r=%0d: got %0d exp %0d", r, events, r);
      end
      in = 3'b000;
      step();
    end
    in_val = 1'b0;
  endtask

  task automatic test_wrap_and_clear();
    logic [1:0] exp_ev [5];
    exp_ev = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    in_val = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in = 3'b111;
      step();
      checks++;
      if ({det2, det_pulse2, events2} !== {2'b11, exp_ev[i]}) begin
        fails++; $display("FAIL wrap det %0d: got det=%b pulse=%b ev=%0d exp 1 1 %0d",
                          i, det2, det_pulse2, events2, exp_ev[i]);
      end
      in = 3'b000;
      step();
      checks++;
      if ({det2, det_pulse2} !== 2'b00) begin
        fails++; $display("FAIL wrap nonmatch %0d: got det/pulse=%b exp 00", i, {det2, det_pulse2});
      end
    end
    clear = 1'b1; in = 3'b111;
    step();
    checks++;
    if ({out_val2, det2, det_pulse2, events2, count2, match2} !== 7'b0000000) begin
      fails++; $display("FAIL clear: got v=%b det=%b pulse=%b ev=%0d c=%0d m=%b exp all 0",
                        out_val2, det2, det_pulse2, events2, count2, match2);
    end
    clear = 1'b0; in_val = 1'b0;
  endtask

  initial begin
    test_reset();
    test_truth_table();
    test_exact_mode();
    test_persistence_bubbles();
    test_back_to_back();
    test_wrap_and_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/majority_persistence_detector.md
# majority_persistence_detector

Parametrised successor to the three-input pair/triple (majority) detector. Each valid cycle it popcounts an NBITS-wide input and compares the count against THRESH, in "at least" or "exactly" mode, through a one-cycle registered stage. A persistence counter asserts `det` only after HOLD consecutive valid matching samples. A saturating-free event counter records each detection. The block sits between raw sensor/flag inputs and downstream control logic that must ignore transient single-sample matches.

## Interface
- `NBITS`, default 3: input vector width, ≥1.
- `THRESH`, default 2: popcount threshold, 0..NBITS.
- `HOLD`, default 4: consecutive valid matches required for detection, ≥1.
- `EW`, default 8: event counter width.
- Derived: CW = $clog2(NBITS+1); RW = $clog2(HOLD+1).

- `clk` input 1: single clock, all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `clear` input 1: synchronous clear of run/detect/event state.
- `in_val` input 1: sample valid.
- `in` input NBITS: sample bits.
- `mode` input 1: 0 = match when popcount ≥ THRESH; 1 = match when popcount == THRESH. Sampled with `in`.
- `out_val` output 1: registered stage holds a sample.
- `count` output CW: registered popcount of the staged sample.
- `match` output 1: registered match of the staged sample.
- `det` output 1: persistence condition met.
- `det_pulse` output 1: one-cycle strobe on `det` rising.
- `events` output EW: number of detections, modulo 2^EW.

## Operation
- Combinational: `pc` = popcount(`in`), `m` = (`mode` ? `pc`==THRESH : `pc`≥THRESH). THRESH=0 with `mode`=0 always matches.
- Stage register: on each edge, `out_val` ← `in_val`. `count`/`match` load `pc`/`m` only when `in_val`=1, else hold. Stage outputs are meaningful only when `out_val`=1.
- Run counter `run` (RW bits):
  - `in_val`=1 & `m`=1 → `run` ← min(`run`+1, HOLD), saturating.
  - `in_val`=1 & `m`=0 → `run` ← 0.
  - `in_val`=0 → `run` holds. Bubbles neither break nor extend a run.
- `det` = (`run` == HOLD), decoded from the register.
- `det_pulse` is registered: set on the edge where `run` goes from HOLD-1 to HOLD; otherwise 0. It therefore coincides with the first cycle `det` is high.
- `events` increments by 1 on the same edge and wraps modulo 2^EW.
- A run that stays saturated produces no further pulses. A new pulse requires a non-match (run→0) and then HOLD fresh matches.
- `clear`=1 has priority over all other activity:
  - `run`, `det_pulse`, `events`, `out_val` ← 0.
  - `count`/`match` hold.
  - A simultaneous `in_val` sample is dropped.
- Reset (`rst_n`=0, any time, including mid-run) asynchronously forces `out_val`=0, `count`=0, `match`=0, `run`=0 (so `det`=0), `det_pulse`=0, `events`=0. Outputs hold these values while `rst_n` is low.
- HOLD=1: the first valid match sets `det` and pulses. A valid non-match drops it.

## Timing
- Latency 1 cycle: a sample presented in cycle t appears on `out_val`/`count`/`match` in cycle t+1.
- Valid matches in cycles t1<…<tHOLD, with no valid non-match between them: `det`=1 and `det_pulse`=1 in cycle tHOLD+1. This is the same cycle the last sample's `match` is visible, and `events` is updated in that cycle.
- Valid non-match in cycle t: `det`=0 from cycle t+1.
- No handshake back-pressure: every valid sample is consumed in its cycle.
- `mode` changes take effect for the sample presented in the same cycle. The run is not reset by a mode change.
- Reset release: the first sample accepted is the one at the first rising edge with `rst_n`=1.

## Test plan
- Reset: drive `in_val`=1, `in`=3'b111 for 5 cycles. Assert `rst_n`=0 mid-cycle → all outputs 0 immediately, before the next edge. After release, `det` needs 4 fresh matches.
- Truth table (defaults, `mode`=0): `in` = 000..111 on consecutive cycles → `count` 0,1,1,2,1,2,2,3 and `match` 0,0,0,1,0,1,1,1, one cycle later, with `out_val`=1.
- Exact mode (`mode`=1): 3'b111 → `match`=0; 3'b101 → `match`=1; 3'b001 → `match`=0.
- Persistence with bubbles: 110, bubble, 011, bubble, bubble, 101, 111 → `det` and `det_pulse` high in the cycle after 111, `events`=1. A 5th match keeps `det`=1 with `det_pulse`=0. Then 100 → `det`=0 next cycle.
- Broken run: 3 matches, then 000, then 4 matches → `det` rises only after the 4th match of the second run; `events`=1.
- Wrap and clear (EW=2, HOLD=1): alternating 111/000 for 5 detections → `events` 1,2,3,0,1. Then `clear`=1 together with `in_val`=1 and `in`=111 → next cycle `out_val`=0, `det`=0, `events`=0.
